// File: rtl/vigna_fetch_queue.sv
// Instruction prefetch queue for the vigna core: sequential word fetch, DEPTH-entry {pc, inst} buffer, redirect flush.
// Optional same-cycle bypass of an empty queue is enabled by defining VIGNA_FETCH_BYPASS_EN.
module vigna_fetch_queue #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 4,
  parameter int          CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  output logic             i_valid,
  input  logic             i_ready,
  output logic [31:0]      i_addr,
  input  logic [31:0]      i_rdata,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [31:0]      inst_pc,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_valid;
  logic [31:0]      r_addr;
  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_inst_mem [DEPTH];
  logic [31:0]      r_pc_mem   [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic             w_valid_next;
  logic [31:0]      w_addr_next;
  logic [31:0]      w_tgt_next;
  logic [31:0]      w_redir_pc;
  logic             w_complete;
  logic             w_bypass;
  logic             w_head_valid;
  logic             w_pop;
  logic             w_push_q;
  logic             w_pop_q;
  logic [CNT_W-1:0] w_count_next;
  logic             w_space;

  assign w_redir_pc   = {redirect_pc[31:2], 2'b00};
  assign w_complete   = r_valid & i_ready;
  assign w_head_valid = (r_count != '0);

`ifdef VIGNA_FETCH_BYPASS_EN
  assign w_bypass = !w_head_valid && (r_state == S_FETCH) && !redirect && w_complete;
`else
  assign w_bypass = 1'b0;
`endif

  assign inst_valid = w_head_valid | w_bypass;
  assign inst       = w_bypass ? i_rdata : r_inst_mem[r_rptr];
  assign inst_pc    = w_bypass ? r_addr  : r_pc_mem[r_rptr];
  assign i_valid    = r_valid;
  assign i_addr     = r_addr;
  assign count      = r_count;

  // A bypassed word that is consumed at once never touches the queue storage.
  assign w_pop        = inst_valid & inst_ready & !redirect;
  assign w_push_q     = w_complete && (r_state == S_FETCH) && !redirect && !(w_bypass && inst_ready);
  assign w_pop_q      = w_pop && w_head_valid;
  assign w_count_next = r_count + CNT_W'(w_push_q) - CNT_W'(w_pop_q);
  assign w_space      = (w_count_next < CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  w_state_next = S_FETCH;
      S_FETCH: if (redirect && r_valid && !i_ready) w_state_next = S_DRAIN;
      S_DRAIN: if (i_ready) w_state_next = S_FETCH;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_valid_next = r_valid;
    w_addr_next  = r_addr;
    w_tgt_next   = redirect ? w_redir_pc : r_fetch_pc;
    case (r_state)
      S_IDLE: begin
        w_valid_next = 1'b1;
        if (redirect) w_addr_next = w_redir_pc;
      end
      S_FETCH: begin
        if (redirect) begin
          // An in-flight request must finish on the bus before the new target can go out.
          if (!(r_valid && !i_ready)) begin
            w_valid_next = 1'b1;
            w_addr_next  = w_redir_pc;
          end
        end else if (w_complete) begin
          w_addr_next  = r_addr + 32'd4;
          w_valid_next = w_space;
        end else if (!r_valid) begin
          w_valid_next = w_space;
        end
      end
      S_DRAIN: begin
        if (i_ready) begin
          w_valid_next = 1'b1;
          w_addr_next  = w_tgt_next;
        end
      end
      default: w_valid_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid    <= 1'b0;
      r_addr     <= RESET_ADDR;
      r_fetch_pc <= RESET_ADDR;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_valid    <= w_valid_next;
      r_addr     <= w_addr_next;
      r_fetch_pc <= w_tgt_next;
      if (redirect) begin
        r_count <= '0;
        r_wptr  <= '0;
        r_rptr  <= '0;
      end else begin
        r_count <= w_count_next;
        r_wptr  <= r_wptr + PTR_W'(w_push_q);
        r_rptr  <= r_rptr + PTR_W'(w_pop_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_q) begin
      r_inst_mem[r_wptr] <= i_rdata;
      r_pc_mem[r_wptr]   <= r_addr;
    end
  end

endmodule

// File: doc/vigna_fetch_queue.md
Name: vigna_fetch_queue

Overview:
- Parametrised instruction prefetch unit for the vigna core family. Generalises the core's single-slot fetch stage into a DEPTH-entry queue.
- Issues sequential word fetches on the instruction valid/ready bus and buffers {pc, instruction} pairs for the execute stage.
- Supports a redirect (branch/jump) that flushes the queue and restarts fetch at a new address, including redirects while a bus request is outstanding.

Parameters:
- RESET_ADDR, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, queue entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- i_valid  out  1  instruction bus request valid (registered).
- i_ready  in  1  bus response strobe; i_rdata is valid in this cycle.
- i_addr  out  32  request address (registered, word aligned).
- i_rdata  in  32  returned instruction word.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  consumer accepts head this cycle.
- inst  out  32  head instruction.
- inst_pc  out  32  address of head instruction.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  32  restart address; bits [1:0] are ignored and forced to 0.
- count  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset, while resetn=0 on a clock edge:
  - i_valid=0, i_addr=RESET_ADDR, inst_valid=0, count=0.
  - State=IDLE; queue pointers=0; fetch_pc=RESET_ADDR.
  - A reset during an outstanding request abandons it; a late i_ready is ignored.
- Bus rules:
  - Once i_valid=1, i_valid and i_addr hold until the cycle i_ready=1.
  - A request is complete in the cycle i_valid && i_ready.
  - i_ready while i_valid=0 is ignored.
- Occupancy rules:
  - push = completed request in FETCH state.
  - pop = inst_valid && inst_ready && !redirect.
  - count updates as count + push - pop; push and pop in the same cycle are both legal.
- Request issue:
  - A request is outstanding, or issued, only when (count + outstanding) < DEPTH.
  - On completion, i_addr advances by 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
  - i_valid stays 1 back-to-back when space remains after accounting for the same-cycle pop; otherwise it drops to 0.
  - When full, i_valid=0. It reasserts the cycle after a pop creates space.
- States:
  - IDLE: one cycle after reset; i_valid <= 1; go to FETCH.
  - FETCH: normal operation as above.
  - DRAIN: a redirect arrived while a request was outstanding and not completing. i_valid and i_addr hold unchanged. On i_ready the response is discarded, i_addr <= saved redirect target, i_valid <= 1, go to FETCH.
- Redirect handling:
  - Redirect has priority over pop and push.
  - Queue flushes in the redirect cycle: count=0 and inst_valid=0 next cycle.
  - The target is latched into fetch_pc.
  - If i_valid=0, or i_valid && i_ready in the same cycle: the response (if any) is dropped; next cycle i_valid=1 and i_addr=target.
  - If i_valid=1 && !i_ready: go to DRAIN.
  - A redirect during DRAIN replaces the saved target; the state stays DRAIN.
- Latency: response-to-inst_valid is 1 cycle (registered queue write).
- Outputs: inst and inst_pc are the registered head entry; their value when inst_valid=0 is don't-care.

Optional Feature:
- Macro: VIGNA_FETCH_BYPASS_EN.
- Defined:
  - When count=0, state=FETCH, no redirect and i_ready: inst_valid=1 combinationally in the same cycle, with inst=i_rdata and inst_pc=i_addr.
  - If inst_ready is also 1, the word is consumed without entering the queue; count stays 0.
  - If inst_ready is 0, the word is written to the queue as normal.
- Not defined: inst/inst_valid come only from queue registers; 1-cycle latency always.

Test Plan:
- Reset, then a slave with i_ready one cycle after each i_valid and inst_ready=1 held:
  - i_addr sequence 0x0, 0x4, 0x8.
  - inst_pc sequence 0x0, 0x4, 0x8, each inst equal to the slave data.
  - count never exceeds 1.
- inst_ready=0 with DEPTH=4, zero-wait slave:
  - After 4 completions i_valid=0 and count=4.
  - Raise inst_ready for one cycle: count=3, then i_valid reasserts with i_addr=0x10.
- Redirect to 0x100 while i_valid=1 and the slave stalls 3 cycles:
  - i_addr holds its old value until i_ready; that response is absent from the queue.
  - Next request is i_addr=0x100; first inst_pc after the redirect is 0x100.
- Redirect to 0x203 coinciding with i_ready and inst_ready:
  - Queue empty next cycle; the response is dropped; no pop counted.
  - Next i_addr=0x200.
- Reset asserted with a request outstanding, slave returns i_ready one cycle later:
  - i_ready ignored; after release the first i_addr is RESET_ADDR and no stale entry reaches inst.
- With VIGNA_FETCH_BYPASS_EN, empty queue, inst_ready=1, i_ready with i_rdata=0x00000013:
  - inst_valid=1 and inst=0x00000013 in the same cycle; count stays 0.
  - Without the macro, inst_valid rises one cycle later.
